// File: rtl/regfile_pkg.sv
// Shared register-file types and defaults for the writeback path and register_file.
// Also holds the writeback requester numbering.
package regfile_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REQ    = 3;

  typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

  localparam reg_idx_t ZERO_REG = '0;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_LSU = 2'd1,
    WB_CSR = 2'd2
  } wb_src_e;

  // Width of an index into n requesters; never zero so a 1-bit pointer still exists.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first requester after 'pointer' (wrapping)
// wins; 'enable' low suppresses every grant.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic          enable,
  input  logic [PW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          grant_any
);

  logic [PW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((32'(pointer) + k) % N);
      if (enable && !grant_any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin share of the register-file write port among NUM_REQ writeback sources,
// with one registered output stage that also feeds operand forwarding.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int NUM_REQ    = regfile_pkg::NUM_REQ
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          hold,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_rd,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          write_enable,
  output logic [ADDR_WIDTH-1:0]         rd,
  output logic [DATA_WIDTH-1:0]         reg_data_in,
  output logic                          fwd_valid,
  output logic [ADDR_WIDTH-1:0]         fwd_rd,
  output logic [DATA_WIDTH-1:0]         fwd_data
);

  localparam int PW = ptr_width(NUM_REQ);

  logic [NUM_REQ-1:0]    grant;
  logic [PW-1:0]         grant_idx;
  logic                  grant_any;
  logic [PW-1:0]         last_grant;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;

  // Grants are gated by reset too, so no source retires while the stage is held clear.
  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr_arbiter (
    .req       (req_valid),
    .enable    (!hold && reset),
    .pointer   (last_grant),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = grant;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_rd   = req_rd[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // x0 writes retire the source and advance the pointer but never strobe the file.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      write_enable <= 1'b0;
      rd           <= '0;
      reg_data_in  <= '0;
      last_grant   <= PW'(NUM_REQ - 1);
    end else if (grant_any) begin
      write_enable <= (sel_rd != ADDR_WIDTH'(ZERO_REG));
      rd           <= sel_rd;
      reg_data_in  <= sel_data;
      last_grant   <= grant_idx;
    end else begin
      write_enable <= 1'b0;
    end
  end

  assign fwd_valid = write_enable;
  assign fwd_rd    = rd;
  assign fwd_data  = reg_data_in;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: per-source request queues drive the DUT,
// a round-robin model predicts grants and output-stage contents.
module tb_regfile_write_arbiter;

  localparam int NR = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             hold  = 1'b0;
  logic [NR-1:0]    req_valid;
  logic [NR*AW-1:0] req_rd;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             write_enable;
  logic [AW-1:0]    rd;
  logic [DW-1:0]    reg_data_in;
  logic             fwd_valid;
  logic [AW-1:0]    fwd_rd;
  logic [DW-1:0]    fwd_data;

  regfile_write_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_REQ    (NR)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .hold         (hold),
    .req_valid    (req_valid),
    .req_rd       (req_rd),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .write_enable (write_enable),
    .rd           (rd),
    .reg_data_in  (reg_data_in),
    .fwd_valid    (fwd_valid),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } exp_t;

  wr_t           src_q[NR][$];
  exp_t          sb[$];
  int            glog[$];
  int            checks = 0;
  int            failures = 0;
  int            exp_ptr;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_data;
  logic [DW-1:0] rf[32];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NR; i++) n += src_q[i].size();
    return n;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (src_q[i].size() > 0);
      if (src_q[i].size() > 0) begin
        req_rd[i*AW +: AW]   = src_q[i][0].rd;
        req_data[i*DW +: DW] = src_q[i][0].data;
      end else begin
        req_rd[i*AW +: AW]   = AW'($urandom);
        req_data[i*DW +: DW] = $urandom;
      end
    end
  endtask

  task automatic model_reset();
    exp_ptr = NR - 1;
    m_rd    = '0;
    m_data  = '0;
    sb.delete();
  endtask

  // One clock: predict grant, check ready, push expected output, then check it after the edge.
  task automatic cycle();
    int            g;
    int            idx;
    logic [NR-1:0] er;
    exp_t          e;
    wr_t           w;
    drive_inputs();
    #1;
    g = -1;
    if (!hold) begin
      for (int k = 1; k <= NR; k++) begin
        idx = (exp_ptr + k) % NR;
        if (g < 0 && src_q[idx].size() > 0) g = idx;
      end
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    if (write_enable) rf[rd] = reg_data_in;
    e.we   = 1'b0;
    e.rd   = m_rd;
    e.data = m_data;
    if (g >= 0) begin
      w       = src_q[g].pop_front();
      m_rd    = w.rd;
      m_data  = w.data;
      e.we    = (w.rd != 0);
      e.rd    = w.rd;
      e.data  = w.data;
      exp_ptr = g;
      glog.push_back(g);
    end
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk("write_enable", 64'(write_enable), 64'(e.we));
      chk("rd", 64'(rd), 64'(e.rd));
      chk("reg_data_in", 64'(reg_data_in), 64'(e.data));
      chk("fwd_valid", 64'(fwd_valid), 64'(e.we));
      chk("fwd_rd", 64'(fwd_rd), 64'(e.rd));
      chk("fwd_data", 64'(fwd_data), 64'(e.data));
    end
    @(negedge clock);
  endtask

  // Run until every source has retired, plus one cycle so the last write is committed.
  task automatic drain(input int budget);
    int n = 0;
    while (pending() > 0 && n < budget) begin
      cycle();
      n++;
    end
    cycle();
    chk("drain_pending", 64'(pending()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_order[5] = '{0, 1, 2, 0, 1};
    int exp_conf[2]  = '{2, 0};

    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    model_reset();

    // Reset state with all sources already requesting.
    src_q[0].push_back(wr_t'{rd: 5'd1, data: 32'h0000_0100});
    src_q[0].push_back(wr_t'{rd: 5'd4, data: 32'h0000_0400});
    src_q[1].push_back(wr_t'{rd: 5'd2, data: 32'h0000_0200});
    src_q[1].push_back(wr_t'{rd: 5'd6, data: 32'h0000_0600});
    src_q[2].push_back(wr_t'{rd: 5'd3, data: 32'h0000_0300});
    drive_inputs();
    #2;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_we", 64'(write_enable), 64'd0);
    chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("rst_rd", 64'(rd), 64'd0);
    chk("rst_data", 64'(reg_data_in), 64'd0);
    chk("rst_fwd_rd", 64'(fwd_rd), 64'd0);
    chk("rst_fwd_data", 64'(fwd_data), 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Grant order after reset release.
    glog.delete();
    drain(20);
    chk("order_len", 64'(glog.size()), 64'd5);
    for (int i = 0; i < 5 && i < glog.size(); i++) chk("order", 64'(glog[i]), 64'(exp_order[i]));
    chk("rf_x4", 64'(rf[4]), 64'h400);

    // Single source write.
    src_q[1].push_back(wr_t'{rd: 5'd5, data: 32'hDEAD_BEEF});
    drain(10);
    chk("rf_x5", 64'(rf[5]), 64'hDEAD_BEEF);

    // x0 write retires but never strobes.
    src_q[0].push_back(wr_t'{rd: 5'd0, data: 32'h0000_1234});
    drain(10);
    chk("rf_x0", 64'(rf[0]), 64'd0);

    // Same rd from two sources with last grant at 0.
    glog.delete();
    src_q[0].push_back(wr_t'{rd: 5'd7, data: 32'h0000_000A});
    src_q[2].push_back(wr_t'{rd: 5'd7, data: 32'h0000_000B});
    drain(10);
    for (int i = 0; i < 2 && i < glog.size(); i++) chk("conflict_order", 64'(glog[i]), 64'(exp_conf[i]));
    chk("rf_x7", 64'(rf[7]), 64'hA);

    // Hold for four cycles with all sources busy.
    for (int i = 0; i < NR; i++) begin
      for (int j = 0; j < 3; j++) begin
        src_q[i].push_back(wr_t'{rd: AW'(10 + i*3 + j), data: $urandom});
      end
    end
    cycle();
    hold = 1'b1;
    repeat (4) cycle();
    hold = 1'b0;
    drain(30);

    // Asynchronous reset while a write is in the output stage.
    src_q[1].push_back(wr_t'{rd: 5'd9, data: 32'h0000_CAFE});
    cycle();
    chk("pre_rst_we", 64'(write_enable), 64'd1);
    #2;
    reset = 1'b0;
    req_valid = '1;
    #1;
    chk("arst_we", 64'(write_enable), 64'd0);
    chk("arst_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("arst_rd", 64'(rd), 64'd0);
    chk("arst_data", 64'(reg_data_in), 64'd0);
    chk("arst_ready", 64'(req_ready), 64'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    glog.delete();
    src_q[2].push_back(wr_t'{rd: 5'd12, data: 32'h0000_0C0C});
    src_q[0].push_back(wr_t'{rd: 5'd11, data: 32'h0000_0B0B});
    drain(10);
    if (glog.size() > 0) chk("post_rst_first", 64'(glog[0]), 64'd0);
    else chk("post_rst_first", 64'(glog.size()), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
